// File: rtl/mul_sn_pkg.sv
// Shared constants and helpers for the pipelined signed/unsigned multiplier.
// abs_u is kept generic (up to MAXW bits) so the divider can reuse it.
package mul_sn_pkg;

    localparam int unsigned MAXW    = 32;
    localparam int unsigned MAX_LAT = 7;

    localparam logic [MAX_LAT-1:0] STAGE_V_RST = '0;

    function automatic int unsigned mul_sn_lat(input int unsigned width);
        return $clog2(width) + 2;
    endfunction

    // Magnitude of a width-bit operand held zero-extended in x; exact for -2^(width-1).
    function automatic logic [MAXW-1:0] abs_u(input logic [MAXW-1:0] x,
                                              input logic            sgn,
                                              input int unsigned     width);
        logic [MAXW-1:0] mask;
        logic            neg;
        mask = '1;
        mask = mask >> (MAXW - width);
        neg  = sgn && x[width-1];
        return neg ? ((~x + MAXW'(1)) & mask) : (x & mask);
    endfunction

endpackage

// File: rtl/mul_sn_tree_lvl.sv
// One adder-tree level: sums adjacent pairs of IN_W-bit partial sums, the odd
// member of each pair weighted by 2^SHIFT. Purely combinational.
module mul_sn_tree_lvl #(
    parameter int unsigned IN_N  = 4,
    parameter int unsigned IN_W  = 10,
    parameter int unsigned SHIFT = 2
) (
    input  logic [IN_N*IN_W-1:0]               i_in,
    output logic [(IN_N/2)*(IN_W+SHIFT)-1:0]   o_sum
);

    localparam int unsigned OUT_W = IN_W + SHIFT;

    always_comb begin
        o_sum = '0;
        for (int unsigned j = 0; j < IN_N / 2; j++) begin
            o_sum[j*OUT_W +: OUT_W] = OUT_W'(i_in[(2*j)*IN_W +: IN_W])
                                    + (OUT_W'(i_in[(2*j+1)*IN_W +: IN_W]) << SHIFT);
        end
    end

endmodule

// File: rtl/mul_sn.sv
// Pipelined WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per op, with
// valid/ready back-pressure, flush and tag passthrough. Depth is $clog2(WIDTH)+2.
module mul_sn
    import mul_sn_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [2*WIDTH-1:0]   o_res,
    output logic [TAG_W-1:0]     o_tag
);

    localparam int unsigned LAT  = mul_sn_lat(WIDTH);
    localparam int unsigned N    = WIDTH / 2;
    localparam int unsigned NLVL = $clog2(N);

    function automatic int unsigned lvl_in_w(input int unsigned l);
        return (l == 0) ? WIDTH + 2 : WIDTH + (2 << l);
    endfunction

    function automatic int unsigned lvl_bits(input int unsigned l);
        return (N >> (l + 1)) * (lvl_in_w(l) + (2 << l));
    endfunction

    function automatic int unsigned lvl_off(input int unsigned l);
        int unsigned acc;
        acc = 0;
        for (int unsigned k = 0; k < l; k++) acc += lvl_bits(k);
        return acc;
    endfunction

    localparam int unsigned TREE_BITS = lvl_off(NLVL);
    localparam int unsigned LAST_OFF  = lvl_off(NLVL - 1);

    // Tree levels are packed back to back at their exact widths in one vector.
    typedef struct packed {
        logic [LAT-1:0]             v;
        logic [LAT-2:0]             inv;
        logic [LAT-1:0][TAG_W-1:0]  tag;
        logic [WIDTH-1:0]           ua;
        logic [WIDTH-1:0]           ub;
        logic [N-1:0][WIDTH+1:0]    rows;
        logic [TREE_BITS-1:0]       tree;
        logic [2*WIDTH-1:0]         res;
    } reg_t;

    reg_t                   r_q, r_d;
    logic                   stall, accept;
    logic [LAT-1:0]         ld;
    logic [TREE_BITS-1:0]   tree_sum, tree_ld;
    logic [2*WIDTH-1:0]     sum;

    always_comb begin
        stall   = r_q.v[LAT-1] && !i_ready;
        o_ready = !stall;
        accept  = i_valid && !stall && !i_flush;
        ld      = '0;
        ld[0]   = accept;
        for (int unsigned s = 1; s < LAT; s++) begin
            ld[s] = !stall && !i_flush && r_q.v[s-1];
        end
    end

    for (genvar l = 0; l < NLVL; l++) begin : g_lvl
        localparam int unsigned IN_N  = N >> l;
        localparam int unsigned IN_W  = lvl_in_w(l);
        localparam int unsigned SHIFT = 2 << l;
        localparam int unsigned OFF   = lvl_off(l);
        localparam int unsigned BITS  = lvl_bits(l);

        logic [IN_N*IN_W-1:0] in_flat;

        if (l == 0) begin : g_first
            assign in_flat = r_q.rows;
        end else begin : g_next
            assign in_flat = r_q.tree[lvl_off(l-1) +: lvl_bits(l-1)];
        end

        mul_sn_tree_lvl #(
            .IN_N  (IN_N),
            .IN_W  (IN_W),
            .SHIFT (SHIFT)
        ) u_lvl (
            .i_in  (in_flat),
            .o_sum (tree_sum[OFF +: BITS])
        );

        assign tree_ld[OFF +: BITS] = {BITS{ld[2+l]}};
    end

    assign sum = r_q.tree[LAST_OFF +: 2*WIDTH];

    always_comb begin
        r_d = r_q;

        if (i_flush) begin
            r_d.v = '0;
        end else if (!stall) begin
            r_d.v = {r_q.v[LAT-2:0], accept};
        end

        if (ld[0]) begin
            r_d.ua     = WIDTH'(abs_u(MAXW'(i_a), i_signed, WIDTH));
            r_d.ub     = WIDTH'(abs_u(MAXW'(i_b), i_signed, WIDTH));
            r_d.inv[0] = i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_d.tag[0] = i_tag;
        end

        // Radix-4 digit rows: ua times each 2-bit slice of ub.
        if (ld[1]) begin
            for (int unsigned k = 0; k < N; k++) begin
                r_d.rows[k] = (WIDTH+2)'(r_q.ua) * (WIDTH+2)'(r_q.ub[2*k +: 2]);
            end
        end

        for (int unsigned s = 1; s < LAT - 1; s++) begin
            if (ld[s]) begin
                r_d.inv[s] = r_q.inv[s-1];
                r_d.tag[s] = r_q.tag[s-1];
            end
        end

        r_d.tree = (tree_sum & tree_ld) | (r_q.tree & ~tree_ld);

        if (ld[LAT-1]) begin
            r_d.res        = r_q.inv[LAT-2] ? -sum : sum;
            r_d.tag[LAT-1] = r_q.tag[LAT-2];
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_q   <= '0;
            r_q.v <= STAGE_V_RST[LAT-1:0];
        end else begin
            r_q <= r_d;
        end
    end

    assign o_valid = r_q.v[LAT-1];
    assign o_res   = r_q.res;
    assign o_tag   = r_q.tag[LAT-1];

endmodule
